// File: rtl/rv32i_fetch_decode_alu.sv
// RV32I fetch/decode/execute slice: sync-read instruction RAM, opcode decoder
// and integer ALU. Decode and ALU are combinational from the fetched word.
module rv32i_fetch_decode_alu #(
  parameter int SIZE_OF_MEMORY = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic [31:0] rs1_v,
  input  logic [31:0] rs2_v,
  output logic [31:0] instruction,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm_i,
  output logic [31:0] imm_u,
  output logic        valid_op,
  output logic        ALU_OP,
  output logic        ALU_I_OP,
  output logic        LOAD_OP,
  output logic        STORE_OP,
  output logic        BRANCH_OP,
  output logic        LUI,
  output logic        AUIPC,
  output logic        JAL,
  output logic        JALR,
  output logic [31:0] alu_result
);
  localparam int AW = $clog2(SIZE_OF_MEMORY);

  logic [31:0]   mem_q [SIZE_OF_MEMORY];
  logic [AW-1:0] raddr, waddr;
  logic [31:0]   instr_d, instr_q;

  // Byte offset and out-of-range PC bits are dropped so addresses wrap.
  assign raddr = pc[AW+1:2];
  assign waddr = imem_waddr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[31:AW+2], pc[1:0], imem_waddr[31:AW+2], imem_waddr[1:0]};

  always_ff @(posedge clk) begin
    if (imem_we) mem_q[waddr] <= imem_wdata;
  end

  // Non-blocking update of mem_q gives read-old-data on a same-word collision.
  assign instr_d = mem_q[raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_q <= '0;
    else        instr_q <= instr_d;
  end

  assign instruction = instr_q;
  assign rs1   = instr_q[19:15];
  assign rs2   = instr_q[24:20];
  assign rd    = instr_q[11:7];
  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_u = {instr_q[31:12], 12'b0};

  always_comb begin
    ALU_OP    = 1'b0;
    ALU_I_OP  = 1'b0;
    LOAD_OP   = 1'b0;
    STORE_OP  = 1'b0;
    BRANCH_OP = 1'b0;
    LUI       = 1'b0;
    AUIPC     = 1'b0;
    JAL       = 1'b0;
    JALR      = 1'b0;
    case (instr_q[6:0])
      7'b0110011: ALU_OP = 1'b1;
      7'b0010011: begin ALU_OP = 1'b1; ALU_I_OP = 1'b1; end
      7'b0000011: LOAD_OP   = 1'b1;
      7'b0100011: STORE_OP  = 1'b1;
      7'b1100011: BRANCH_OP = 1'b1;
      7'b0110111: LUI       = 1'b1;
      7'b0010111: AUIPC     = 1'b1;
      7'b1101111: JAL       = 1'b1;
      7'b1100111: JALR      = 1'b1;
      default: ;
    endcase
  end

  assign valid_op = ALU_OP | LOAD_OP | STORE_OP | BRANCH_OP | LUI | AUIPC | JAL | JALR;

  logic [31:0]        val2;
  logic [4:0]         shamt;
  logic [2:0]         funct3;
  logic               mod;
  logic signed [31:0] sra_res;

  assign val2    = ALU_I_OP ? imm_i : rs2_v;
  assign shamt   = val2[4:0];
  assign funct3  = instr_q[14:12];
  assign mod     = instr_q[30];
  // Kept in a signed net so the arithmetic shift is not demoted by context.
  assign sra_res = $signed(rs1_v) >>> shamt;

  always_comb begin
    alu_result = '0;
    case (funct3)
      3'b000: alu_result = (mod && !ALU_I_OP) ? rs1_v - val2 : rs1_v + val2;
      3'b001: alu_result = rs1_v << shamt;
      3'b010: alu_result = {31'b0, $signed(rs1_v) < $signed(val2)};
      3'b011: alu_result = {31'b0, rs1_v < val2};
      3'b100: alu_result = rs1_v ^ val2;
      3'b101: alu_result = mod ? sra_res : rs1_v >> shamt;
      3'b110: alu_result = rs1_v | val2;
      3'b111: alu_result = rs1_v & val2;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rv32i_fetch_decode_alu.sv
// Self-checking bench: directed cases plus random fetch/write traffic against
// a word-array memory model and an arithmetic ALU/decoder reference.
module tb_rv32i_fetch_decode_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = '0;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = '0, imem_wdata = '0;
  logic [31:0] rs1_v = '0, rs2_v = '0;
  logic [31:0] instruction, imm_i, imm_u, alu_result;
  logic [4:0]  rs1, rs2, rd;
  logic        valid_op, ALU_OP, ALU_I_OP, LOAD_OP, STORE_OP, BRANCH_OP;
  logic        LUI, AUIPC, JAL, JALR;

  int n_chk = 0, n_err = 0;
  logic [31:0] shadow [256];

  rv32i_fetch_decode_alu #(.SIZE_OF_MEMORY(256)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .rs1_v(rs1_v), .rs2_v(rs2_v),
    .instruction(instruction), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm_i(imm_i), .imm_u(imm_u),
    .valid_op(valid_op), .ALU_OP(ALU_OP), .ALU_I_OP(ALU_I_OP),
    .LOAD_OP(LOAD_OP), .STORE_OP(STORE_OP), .BRANCH_OP(BRANCH_OP),
    .LUI(LUI), .AUIPC(AUIPC), .JAL(JAL), .JALR(JALR),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  wire [9:0] dflags = {valid_op, ALU_OP, ALU_I_OP, LOAD_OP, STORE_OP,
                       BRANCH_OP, LUI, AUIPC, JAL, JALR};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flag order: valid, ALU, ALU_I, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR
  function automatic logic [9:0] ref_flags(input logic [6:0] op);
    case (op)
      7'h33: return 10'h300;
      7'h13: return 10'h380;
      7'h03: return 10'h240;
      7'h23: return 10'h220;
      7'h63: return 10'h210;
      7'h37: return 10'h208;
      7'h17: return 10'h204;
      7'h6f: return 10'h202;
      7'h67: return 10'h201;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
    bit          is_imm = (ins[6:0] == 7'h13);
    logic [31:0] v2 = is_imm ? {{20{ins[31]}}, ins[31:20]} : b;
    int          sh = int'(v2[4:0]);
    logic [31:0] ones = 32'hFFFF_FFFF;
    case (ins[14:12])
      3'd0: return (ins[30] && !is_imm) ? a - v2 : a + v2;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(v2)) ? 32'd1 : 32'd0;
      3'd3: return (a < v2) ? 32'd1 : 32'd0;
      3'd4: return a ^ v2;
      3'd5: return ins[30] ? ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0)) : a >> sh;
      3'd6: return a | v2;
      default: return a & v2;
    endcase
  endfunction

  task automatic check_all(input logic [31:0] e);
    chk("instr", instruction, e);
    chk("flags", {22'b0, dflags}, {22'b0, ref_flags(e[6:0])});
    chk("fields", {17'b0, rs1, rs2, rd}, {17'b0, e[19:15], e[24:20], e[11:7]});
    chk("imm_i", imm_i, {{20{e[31]}}, e[31:20]});
    chk("imm_u", imm_u, {e[31:12], 12'b0});
    chk("alu", alu_result, ref_alu(e, rs1_v, rs2_v));
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'd255);
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = addr; imem_wdata = data;
    @(posedge clk);
    shadow[widx(addr)] = data;
    #1 imem_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    @(negedge clk);
    pc = p; rs1_v = a; rs2_v = b;
    e = shadow[widx(p)];
    @(posedge clk);
    #1 check_all(e);
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    wr(32'h10, ins);
    fetch(32'h10, a, b);
    chk(tag, alu_result, exp);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
    logic [31:0] ins = $urandom();
    int          r = int'($urandom_range(0, 10));
    if (r < 9) ins[6:0] = ops[r];
    return ins;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [6:0]  sw_op [7] = '{7'h03, 7'h23, 7'h63, 7'h17, 7'h6f, 7'h67, 7'h00};
    logic [9:0]  sw_fl [7] = '{10'h240, 10'h220, 10'h210, 10'h204, 10'h202, 10'h201, 10'h000};
    logic [31:0] e, old_w;

    rs1_v = 32'd7; rs2_v = 32'd9;
    #1 rst_n = 1'b0;
    #1 chk("rst_instr", instruction, 32'h0);
    chk("rst_flags", {22'b0, dflags}, 32'h0);
    chk("rst_alu", alu_result, 32'd16);
    @(posedge clk); #1 check_all(32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 256; i++) wr(32'(i * 4), rand_instr());

    // ADDI x1, x0, 5
    wr(32'h0, 32'h0050_0093);
    fetch(32'h0, 32'h0, 32'h0);
    chk("addi_alu", alu_result, 32'd5);
    chk("addi_rd", {27'b0, rd}, 32'd1);
    chk("addi_flags", {22'b0, dflags}, 32'h380);

    run_alu("addi_bit30", 32'h4000_8093, 32'd1, 32'd0, 32'd1025);
    run_alu("sub", 32'h4020_8033, 32'd10, 32'd3, 32'd7);
    run_alu("srai", 32'h4010_d093, 32'h8000_0000, 32'd0, 32'hC000_0000);
    run_alu("srli", 32'h0010_d093, 32'h8000_0000, 32'd0, 32'h4000_0000);
    run_alu("slt", 32'h0020_a033, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_alu("sltu", 32'h0020_b033, 32'hFFFF_FFFF, 32'd1, 32'd0);

    wr(32'h14, 32'h1234_50b7);
    fetch(32'h14, 32'h0, 32'h0);
    chk("lui_flags", {22'b0, dflags}, 32'h208);
    chk("lui_imm_u", imm_u, 32'h1234_5000);

    for (int i = 0; i < 7; i++) begin
      wr(32'h18, {25'b0, sw_op[i]});
      fetch(32'h18, $urandom(), $urandom());
      chk("decode_sweep", {22'b0, dflags}, {22'b0, sw_fl[i]});
    end

    // Address wrap on both ports.
    wr(32'h0, 32'hCAFE_0013);
    fetch(32'h400, 32'h0, 32'h0);
    chk("wrap_read", instruction, 32'hCAFE_0013);
    wr(32'h404, 32'hBEEF_0033);
    fetch(32'h4, 32'h0, 32'h0);
    chk("wrap_write", instruction, 32'hBEEF_0033);

    // Same-word read and write in one cycle returns the old word.
    old_w = shadow[8];
    @(negedge clk);
    pc = 32'h20; imem_we = 1'b1; imem_waddr = 32'h20; imem_wdata = 32'h0AB0_0093;
    @(posedge clk);
    shadow[8] = 32'h0AB0_0093;
    #1 imem_we = 1'b0;
    chk("rw_old", instruction, old_w);
    fetch(32'h20, 32'h0, 32'h0);
    chk("rw_new", instruction, 32'h0AB0_0093);

    // Asynchronous reset mid-cycle, memory retained.
    fetch(32'h10, 32'd4, 32'd6);
    #2 rst_n = 1'b0;
    #1 check_all(32'h0);
    chk("midrst_alu", alu_result, 32'd10);
    @(negedge clk) rst_n = 1'b1;
    fetch(32'h10, 32'd4, 32'd6);
    chk("mem_survives", instruction, shadow[4]);

    // Random concurrent fetch/write traffic.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      pc = $urandom(); rs1_v = rand_val(); rs2_v = rand_val();
      imem_we = ($urandom_range(0, 1) == 1);
      imem_waddr = $urandom(); imem_wdata = rand_instr();
      e = shadow[widx(pc)];
      @(posedge clk);
      if (imem_we) shadow[widx(imem_waddr)] = imem_wdata;
      #1 check_all(e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
